// File: rtl/burst_requester_pkg.sv
// Shared FSM state encoding and default parameters for burst_requester.
// Optional grant-wait timeout is enabled by defining REQ_TIMEOUT_EN.
package burst_requester_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam int DEF_FIFO_DEPTH     = 4;
    localparam int DEF_LEN_W          = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/burst_requester_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy and full/empty flags.
// Head entry is presented on dout whenever the FIFO is non-empty.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/burst_requester.sv
// Queues burst commands and requests the arbiter once per burst, strobing one beat per cycle.
// Define REQ_TIMEOUT_EN to abandon grant waits after TIMEOUT_CYCLES and re-request later.
module burst_requester
    import burst_requester_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    input  logic [LEN_W-1:0]              cmd_len,
    output logic                          cmd_ready,
    output logic                          req,
    input  logic                          gnt,
    output logic                          beat,
    output logic                          done,
    output logic                          timeout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic             fifo_full, fifo_empty, fifo_pop, cmd_push;
    logic [LEN_W-1:0] fifo_head;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             beat_q, beat_d;
    logic             done_q, done_d;

    // Command handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready depends only on FIFO fullness, never on cmd_valid.
    assign cmd_ready = ~fifo_full;
    assign cmd_push  = cmd_valid & ~fifo_full;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (LEN_W)
    ) u_cmd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cmd_push),
        .din   (cmd_len),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
`ifdef REQ_TIMEOUT_EN
        wait_d    = '0;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = REQ;
                    cnt_d   = fifo_head;
                end
            end
            REQ: begin
                if (gnt) begin
                    state_d = XFER;
`ifdef REQ_TIMEOUT_EN
                end else if (wait_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // Head stays queued, so the next IDLE reloads the same command.
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            XFER: begin
                if (cnt_q == '0) begin
                    fifo_pop = 1'b1;
                    state_d  = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                if (!gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are computed from the next state so the registered copies line up with it.
        req_d  = (state_d == REQ) || (state_d == XFER);
        beat_d = (state_d == XFER);
        done_d = (state_d == XFER) && (cnt_d == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            beat_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef REQ_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
`ifdef REQ_TIMEOUT_EN
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign req  = req_q;
    assign beat = beat_q;
    assign done = done_q;
`ifdef REQ_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_burst_requester.sv
// Randomized bench for burst_requester against a beats-remaining reference model.
// Timeout behaviour is modelled when REQ_TIMEOUT_EN is defined.
module tb_burst_requester;

    localparam int DEPTH  = 4;
    localparam int LEN_W  = 4;
    localparam int TO_CYC = 16;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             gnt = 1'b0;
    logic             cmd_ready, req, beat, done, timeout;
    logic [CW-1:0]    fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queued commands, beats still to transfer, and wait flags.
    logic [LEN_W-1:0] exp_q[$];
    int m_left;
    bit m_req, m_release, m_to;
    int m_wait;

    burst_requester #(
        .FIFO_DEPTH     (DEPTH),
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .req        (req),
        .gnt        (gnt),
        .beat       (beat),
        .done       (done),
        .timeout    (timeout),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_left    = 0;
        m_req     = 1'b0;
        m_release = 1'b0;
        m_to      = 1'b0;
        m_wait    = 0;
    endtask

    // Advances the model by one rising edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit push, pop;
        if (reset) begin
            model_clear();
            return;
        end
        push = cmd_valid && (exp_q.size() < DEPTH);
        pop  = (m_left == 1);
        m_to = 1'b0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_release = 1'b1;
        end else if (m_req) begin
            if (gnt) begin
                m_req  = 1'b0;
                m_left = int'(exp_q[0]) + 1;
                m_wait = 0;
            end
`ifdef REQ_TIMEOUT_EN
            else begin
                m_wait++;
                if (m_wait == TO_CYC) begin
                    m_req     = 1'b0;
                    m_release = 1'b1;
                    m_to      = 1'b1;
                    m_wait    = 0;
                end
            end
`endif
        end else if (m_release) begin
            if (!gnt) m_release = 1'b0;
        end else if (exp_q.size() > 0) begin
            m_req = 1'b1;
        end
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(cmd_len);
    endtask

    task automatic compare_all();
        check_val("req",        32'(req),        32'(m_req || (m_left > 0)));
        check_val("beat",       32'(beat),       32'(m_left > 0));
        check_val("done",       32'(done),       32'(m_left == 1));
        check_val("timeout",    32'(timeout),    32'(m_to));
        check_val("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        check_val("cmd_ready",  32'(cmd_ready),  32'(exp_q.size() < DEPTH));
    endtask

    task automatic drive_cycle(input bit rst, input bit v, input logic [LEN_W-1:0] len, input bit g);
        @(negedge clock);
        reset     = rst;
        cmd_valid = v;
        cmd_len   = len;
        gnt       = g;
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    // Per phase: cycles, cmd_valid %, gnt %, reset per-mille.
    int ph_cycles [6] = '{12, 400, 300, 400, 400, 300};
    int ph_valid  [6] = '{100, 50, 30, 80, 20, 100};
    int ph_gnt    [6] = '{0, 50, 100, 70, 20, 90};
    int ph_rst    [6] = '{0, 0, 0, 5, 0, 0};

    initial begin
        model_clear();
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        drive_cycle(1'b1, 1'b1, 4'd5, 1'b1);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < ph_cycles[p]; c++) begin
                drive_cycle($urandom_range(999, 0) < ph_rst[p],
                            $urandom_range(99, 0) < ph_valid[p],
                            LEN_W'($urandom_range(15, 0)),
                            $urandom_range(99, 0) < ph_gnt[p]);
            end
        end
        // Reset in the middle of a burst with commands still queued.
        for (int c = 0; c < 200; c++) begin
            if (m_left > 1 && exp_q.size() >= 2) break;
            drive_cycle(1'b0, 1'b1, LEN_W'($urandom_range(15, 3)), 1'b1);
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b1);
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, 1'b0, '0, $urandom_range(1, 0) == 1);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_requester.md
BURST_REQUESTER -- requirements
Module: burst_requester

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the command FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter LEN_W, default 4, SHALL set the width of the burst-length field.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, SHALL set the grant-wait limit in cycles (used only with REQ_TIMEOUT_EN).
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  upstream offers a burst command.
REQ-007 cmd_len  input  LEN_W  beats minus one (0 = 1 beat, 15 = 16 beats).
REQ-008 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-009 req  output  1  active-high request to the arbiter.
REQ-010 gnt  input  1  active-high grant from the arbiter.
REQ-011 beat  output  1  one data-transfer strobe per granted beat.
REQ-012 done  output  1  one-cycle pulse on the last beat of a burst.
REQ-013 timeout  output  1  one-cycle pulse when a grant wait is abandoned.
REQ-014 fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Push SHALL occur when cmd_valid and cmd_ready are both 1; cmd_ready SHALL equal not-full, with no bypass and no full-cycle push-on-pop.
REQ-016 Pop SHALL occur only on the last beat of a burst; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-017 The FSM SHALL have four states: IDLE, REQ, XFER, RELEASE.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL move to REQ and load the beat counter from the FIFO head.
REQ-019 In REQ with gnt=1, the FSM SHALL move to XFER.
REQ-020 In XFER, beat SHALL be 1 every cycle and the counter SHALL decrement; when the counter is 0, the FSM SHALL assert done, pop the FIFO and move to RELEASE.
REQ-021 In RELEASE, the FSM SHALL hold until gnt=0 and then move to IDLE. This tolerates the arbiter's registered grant lingering after req falls.
REQ-022 All outputs SHALL be registered.
REQ-023 req SHALL be 1 exactly in REQ and XFER.
REQ-024 gnt seen in IDLE or RELEASE SHALL be ignored.
REQ-025 If gnt drops mid-XFER, beats SHALL continue to count down (the grant is owned until req falls).
REQ-026 Minimum spacing between bursts SHALL be two cycles (RELEASE, IDLE), even if gnt is already 0.

Reset
REQ-027 Reset SHALL force state to IDLE, empty the FIFO, clear the counters, and drive req, beat, done, timeout, fifo_count=0 and cmd_ready=1 on the next edge.
REQ-028 Reset mid-XFER SHALL discard the in-flight burst and all queued commands without a done pulse.

Configuration
REQ-029 With macro REQ_TIMEOUT_EN defined, a wait counter SHALL count REQ cycles with gnt=0. On reaching TIMEOUT_CYCLES it SHALL pulse timeout, move to RELEASE without popping, and later re-request the same command.
REQ-030 Without REQ_TIMEOUT_EN, REQ SHALL wait indefinitely, the timeout port SHALL remain present, and timeout SHALL be tied 0.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (IDLE=0, REQ=1, XFER=2, RELEASE=3) and the default parameter constants.
REQ-032 The FIFO SHALL be the sub-module cmd_fifo (synchronous, registered count, full/empty flags); the FSM and counters SHALL stay in burst_requester.

Verification
REQ-033 Single burst: push len=3, gnt rises 2 cycles after req -> 4 beat pulses, done on the 4th beat, req falls the next cycle, fifo_count goes 1->0.
REQ-034 Fill: push 5 commands back-to-back with gnt=0 -> 4 accepted, cmd_ready=0 on the 5th cycle, fifo_count=4.
REQ-035 Lingering grant: hold gnt=1 for 2 cycles after done -> FSM stays in RELEASE, no new req until 1 cycle after gnt=0.
REQ-036 Push+pop: push on the same cycle as the last beat with fifo_count=2 -> fifo_count stays 2.
REQ-037 Timeout (REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): gnt held 0 -> timeout pulses at cycle 16, req drops, re-request occurs, fifo_count is unchanged.
REQ-038 Reset mid-XFER, 2 queued -> next cycle req=0, beat=0, fifo_count=0, and no done pulse.
